mem_access: RTL and testbench

//  Memory-stage load/store unit of the 5-stage RV32I pipeline; sits between the EX/MEM register and dm_wb.

---
 rtl/mem_access.sv | 102 ++++++++++
 tb/tb_mem_access.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: RV32I memory-stage load/store unit driving a req/ack data bus
module mem_access #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] rdata_q;
  logic        is_load, acc, legal, mis, go;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;
  assign is_load   = ResultSrcM == 2'b01;
  assign acc       = MemWriteM | is_load;
  assign legal     = (funct3M inside {3'b000, 3'b001, 3'b010}) |
                     (~MemWriteM & (funct3M inside {3'b100, 3'b101}));
  assign mis       = (funct3M[1:0] == 2'b01 & ALUResultM[0]) |
                     (funct3M[1:0] == 2'b10 & |ALUResultM[1:0]);
  assign go        = acc & legal & ~mis;
  assign MisalignM = state_q == IDLE & acc & ~(legal & ~mis);
  assign StallM    = (state_q == IDLE & go) | state_q == BUSY;
  assign ReadDataM = state_q == DONE ? rdata_q : 32'd0;
  // Lane-select enables and replicated store data for the access being issued
  always_comb begin
    be_d    = funct3M[1] ? 4'b1111 : funct3M[0] ? (ALUResultM[1] ? 4'b1100 : 4'b0011) : 4'b0001 << ALUResultM[1:0];
    wdata_d = funct3M[1] ? WriteDataM : funct3M[0] ? {2{WriteDataM[15:0]}} : {4{WriteDataM[7:0]}};
  end
  // Pick the addressed byte/half of the returned word and extend it
  always_comb begin
    ld_b   = 8'(dmem_rdata >> {off_q, 3'b000});
    ld_h   = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_ext = f3_q[1] ? dmem_rdata :
             f3_q[0] ? {{16{ld_h[15] & ~f3_q[2]}}, ld_h} :
                       {{24{ld_b[7] & ~f3_q[2]}}, ld_b};
  end
  // Bus transaction FSM: issue, wait for ack or timeout, present result for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      rdata_q    <= '0;
      BusErrM    <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
    end else begin
      BusErrM <= 1'b0;
      case (state_q)
        IDLE: if (go) begin
          state_q    <= BUSY;
          cnt_q      <= '0;
          f3_q       <= funct3M;
          off_q      <= ALUResultM[1:0];
          dmem_req   <= 1'b1;
          dmem_we    <= MemWriteM;
          dmem_addr  <= {ALUResultM[31:2], 2'b00};
          dmem_be    <= be_d;
          dmem_wdata <= wdata_d;
        end
        BUSY: if (dmem_ack || cnt_q == CW'(TIMEOUT - 1)) begin
          state_q  <= DONE;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
          dmem_be  <= '0;
          rdata_q  <= (dmem_ack & ~dmem_we) ? ld_ext : 32'd0;
          BusErrM  <= ~dmem_ack;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized load/store transactions checked against a behavioural model
module tb_mem_access;
  localparam int TO = 16;
  logic        clk = 0, reset = 1;
  logic        MemWriteM, StallM, MisalignM, BusErrM, dmem_req, dmem_we, dmem_ack;
  logic [1:0]  ResultSrcM;
  logic [2:0]  funct3M;
  logic [3:0]  dmem_be;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM, dmem_addr, dmem_wdata, dmem_rdata;
  int npass = 0, ntot = 0;

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .funct3M(funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit ref_bad(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int size = 1 << (f3 % 4);
    bit ok = f3 <= 2 || (!st && (f3 == 4 || f3 == 5));
    return !ok || (a % size != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    longint v;
    int sh = 8 * (a % 4);
    if (f3 == 2) return rd;
    if (f3 % 4 == 0) begin
      v = (rd >> sh) % 256;
      if (f3 == 0 && v >= 128) v -= 256;
    end else begin
      v = (rd >> sh) % 65536;
      if (f3 == 1 && v >= 32768) v -= 65536;
    end
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    MemWriteM = 0; ResultSrcM = 0; funct3M = 0; ALUResultM = 0; WriteDataM = 0;
  endtask

  // kind: 0 load, 1 store, 2 no memory access; dly: BUSY cycles before ack (>=TO means never)
  task automatic run_txn(input int kind, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int dly);
    bit st = kind == 1;
    bit bad;
    int reqc = 0;
    int expc = dly < TO ? dly + 1 : TO;
    logic [31:0] exp_be, exp_wd;
    MemWriteM = st;
    ResultSrcM = kind == 0 ? 2'b01 : kind == 1 ? 2'b00 : ($urandom % 2 ? 2'b10 : 2'b11);
    funct3M = f3; ALUResultM = a; WriteDataM = wd; dmem_rdata = rd; dmem_ack = 0;
    #1;
    if (kind == 2) begin
      chk("noacc_misalign", MisalignM, 0);
      chk("noacc_stall", StallM, 0);
      @(posedge clk); #1;
      chk("noacc_req", dmem_req, 0);
      idle_inputs();
      return;
    end
    bad = ref_bad(st, f3, a);
    chk("misalign", MisalignM, bad);
    chk("stall_idle", StallM, !bad);
    chk("readdata_idle", ReadDataM, 0);
    @(posedge clk); #1;
    if (bad) begin
      chk("req_bad", dmem_req, 0);
      chk("readdata_bad", ReadDataM, 0);
      idle_inputs();
      return;
    end
    case (f3 % 4)
      0: begin exp_be = 32'(1 << (a % 4)); exp_wd = wd[7:0] * 32'h01010101; end
      1: begin exp_be = 32'(3 << (a % 4)); exp_wd = wd[15:0] * 32'h00010001; end
      default: begin exp_be = 15; exp_wd = wd; end
    endcase
    chk("we", dmem_we, st);
    chk("addr", dmem_addr, a & ~32'd3);
    if (st) chk("wdata", dmem_wdata, exp_wd);
    while (dmem_req && reqc < TO + 4) begin
      reqc++;
      chk("stall_busy", StallM, 1);
      chk("be", dmem_be, exp_be);
      chk("readdata_busy", ReadDataM, 0);
      dmem_ack = (reqc - 1 == dly);
      @(posedge clk); #1;
    end
    dmem_ack = 1'($urandom);
    chk("req_cycles", reqc, expc);
    chk("stall_done", StallM, 0);
    chk("buserr", BusErrM, dly >= TO);
    chk("be_done", dmem_be, 0);
    if (!st) chk("readdata_done", ReadDataM, dly >= TO ? 32'd0 : ref_load(f3, a, rd));
    idle_inputs();
    @(posedge clk); #1;
    dmem_ack = 0;
    chk("buserr_after", BusErrM, 0);
    chk("readdata_after", ReadDataM, 0);
    chk("req_after", dmem_req, 0);
  endtask

  initial begin
    idle_inputs();
    dmem_ack = 0; dmem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_buserr", BusErrM, 0);
    chk("rst_readdata", ReadDataM, 0);
    chk("rst_stall", StallM, 0);
    reset = 0;
    @(posedge clk); #1;
    run_txn(0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 1);
    run_txn(0, 3'b000, 32'h103, 0, 32'h80112233, 0);
    run_txn(0, 3'b100, 32'h103, 0, 32'h80112233, 0);
    run_txn(0, 3'b001, 32'h102, 0, 32'h80112233, 2);
    run_txn(0, 3'b101, 32'h102, 0, 32'h80112233, 0);
    run_txn(1, 3'b001, 32'h202, 32'h1234ABCD, 0, 0);
    run_txn(1, 3'b000, 32'h301, 32'h000000A5, 0, 3);
    run_txn(0, 3'b010, 32'h101, 0, 32'h1, 0);
    run_txn(0, 3'b011, 32'h100, 0, 32'h1, 0);
    run_txn(1, 3'b100, 32'h100, 32'h5, 0, 0);
    run_txn(0, 3'b001, 32'h103, 0, 32'h1, 0);
    run_txn(0, 3'b010, 32'h400, 0, 32'h55AA55AA, TO + 2);
    run_txn(0, 3'b010, 32'h404, 0, 32'h12345678, TO - 1);
    run_txn(2, 3'b010, 32'h404, 0, 0, 0);
    // reset during the second BUSY cycle, then the same load re-issues
    MemWriteM = 0; ResultSrcM = 2'b01; funct3M = 3'b010; ALUResultM = 32'h100;
    dmem_rdata = 32'hCAFEF00D; dmem_ack = 0;
    @(posedge clk); #1;
    chk("rst_busy1_req", dmem_req, 1);
    @(posedge clk); #1;
    chk("rst_busy2_req", dmem_req, 1);
    reset = 1;
    @(posedge clk); #1;
    chk("rst_mid_req", dmem_req, 0);
    chk("rst_mid_be", dmem_be, 0);
    reset = 0;
    run_txn(0, 3'b010, 32'h100, 0, 32'hCAFEF00D, 0);
    for (int i = 0; i < 200; i++) begin
      int r = $urandom % 10;
      int kind = r < 5 ? 0 : r < 9 ? 1 : 2;
      logic [2:0] f3;
      logic [31:0] a = $urandom;
      int dly;
      if ($urandom % 4 == 0) f3 = 3'($urandom);
      else case ($urandom % 5)
        0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010; 3: f3 = 3'b100; default: f3 = 3'b101;
      endcase
      if ($urandom % 2) a = a & ~((32'd1 << (f3 % 4)) - 1);
      dly = ($urandom % 10 == 0) ? TO + int'($urandom % 3) :
            ($urandom % 16 == 0) ? TO - 1 : int'($urandom % 4);
      run_txn(kind, f3, a, $urandom, $urandom, dly);
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
